posicionador_embarcacao: RTL and testbench

- Upstream stage of the per-ship VGA renderers. It turns player button presses into a packed 64-bit ship-position vector, `posicoesEmbarcacao`, which is consumed directly by the ship drawing blocks.
- It keeps an anchor cell and an orientation, clamps the ship to the 8x8 board, and checks the ship against an occupancy map on confirm.
- On a clean confirm it locks the placement and asserts `pronto`.

---
 rtl/embarcacao_pkg.sv | 34 +++
 rtl/detector_borda.sv | 22 ++
 rtl/posicionador_embarcacao.sv | 167 ++++++++++++++++
 tb/tb_posicionador_embarcacao.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/embarcacao_pkg.sv
// Shared constants, types and helpers for the ship placement block.
package embarcacao_pkg;

  // Packed output vector layout: cell k spans [8k+10 : 8k+3].
  localparam int CellStride   = 8;
  localparam int CellXOffset  = 6;
  localparam int CellYOffset  = 10;
  localparam int NumCelulas   = 7;

  // Flag bits in the low end of the vector.
  localparam int BitVisivel    = 0;
  localparam int BitOrientacao = 1;
  localparam int BitFixado     = 2;

  // Board geometry; coordinate codes run CodigoMin..TamTabuleiro.
  localparam int TamTabuleiro = 8;
  localparam int CodigoMin    = 1;

  localparam logic OrientHorizontal = 1'b0;
  localparam logic OrientVertical   = 1'b1;

  typedef enum logic [1:0] {
    StOcioso,
    StPosicionando,
    StVerificando,
    StFixado
  } estado_e;

  // Occupancy bitmap index for 1-based codes: (y-1)*8 + (x-1), mod-64 arithmetic.
  function automatic logic [5:0] endereco_celula(input logic [3:0] x, input logic [3:0] y);
    return {2'b00, y} * 6'd8 + {2'b00, x} - 6'd9;
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: one history flop, combinational pulse on the first high sample.
module detector_borda (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sinal_i,
  output logic borda_o
);

  logic hist_q, hist_d;

  // History follows the input every cycle.
  always_comb hist_d = sinal_i;

  // History register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) hist_q <= 1'b0;
    else       hist_q <= hist_d;
  end

  assign borda_o = sinal_i & ~hist_q;

endmodule

// File: rtl/posicionador_embarcacao.sv
// Ship placement: button-driven anchor/orientation, board clamping, overlap check
// on confirm, and the packed position vector for the ship renderers.
module posicionador_embarcacao
  import embarcacao_pkg::*;
#(
  parameter int unsigned TAMANHO   = 4,
  parameter int unsigned X_INICIAL = 1,
  parameter int unsigned Y_INICIAL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        habilita,
  input  logic        cima,
  input  logic        baixo,
  input  logic        esquerda,
  input  logic        direita,
  input  logic        girar,
  input  logic        confirmar,
  input  logic [63:0] ocupacao,
  output logic [63:0] posicoesEmbarcacao,
  output logic        pronto,
  output logic        rejeitado
);

  // Distance from anchor to the far cell, widened so bound checks cannot wrap.
  localparam logic [4:0] Ext       = 5'(TAMANHO - 1);
  localparam logic [4:0] Limite    = 5'(TamTabuleiro);
  localparam logic [3:0] AncoraMax = 4'(TamTabuleiro + 1 - int'(TAMANHO));
  localparam logic [2:0] IdxUltimo = 3'(TAMANHO - 1);
  localparam logic [3:0] CodMin    = 4'(CodigoMin);

  logic b_cima, b_baixo, b_esquerda, b_direita, b_girar, b_confirmar;

  detector_borda u_borda_cima (
    .clk_i(clk), .rst_i(rst), .sinal_i(cima), .borda_o(b_cima)
  );
  detector_borda u_borda_baixo (
    .clk_i(clk), .rst_i(rst), .sinal_i(baixo), .borda_o(b_baixo)
  );
  detector_borda u_borda_esquerda (
    .clk_i(clk), .rst_i(rst), .sinal_i(esquerda), .borda_o(b_esquerda)
  );
  detector_borda u_borda_direita (
    .clk_i(clk), .rst_i(rst), .sinal_i(direita), .borda_o(b_direita)
  );
  detector_borda u_borda_girar (
    .clk_i(clk), .rst_i(rst), .sinal_i(girar), .borda_o(b_girar)
  );
  detector_borda u_borda_confirmar (
    .clk_i(clk), .rst_i(rst), .sinal_i(confirmar), .borda_o(b_confirmar)
  );

  estado_e     estado_q, estado_d;
  logic [3:0]  ax_q, ax_d, ay_q, ay_d;
  logic        orient_q, orient_d;
  logic [2:0]  idx_q, idx_d;
  logic        rej_q, rej_d;
  logic [63:0] pos_q, pos_d;

  logic [4:0]  fim_x, fim_y;
  logic [3:0]  cel_x, cel_y;
  logic        vertical;

  assign vertical = (orient_q == OrientVertical);

  // Far-end coordinates of the ship and the cell under check this cycle.
  always_comb begin
    fim_x = {1'b0, ax_q} + (vertical ? 5'd0 : Ext);
    fim_y = {1'b0, ay_q} + (vertical ? Ext : 5'd0);
    cel_x = ax_q + (vertical ? 4'd0 : {1'b0, idx_q});
    cel_y = ay_q + (vertical ? {1'b0, idx_q} : 4'd0);
  end

  // FSM next state, anchor/orientation moves and overlap check.
  always_comb begin
    estado_d = estado_q;
    ax_d     = ax_q;
    ay_d     = ay_q;
    orient_d = orient_q;
    idx_d    = idx_q;
    rej_d    = 1'b0;
    case (estado_q)
      StOcioso: begin
        if (habilita) estado_d = StPosicionando;
      end
      StPosicionando: begin
        if (!habilita) begin
          estado_d = StOcioso;
        end else if (b_confirmar) begin
          estado_d = StVerificando;
          idx_d    = 3'd0;
        end else if (b_girar) begin
          orient_d = ~orient_q;
          // Rotation always happens; pull the anchor back if the new axis overflows.
          if (vertical) begin
            if ({1'b0, ax_q} + Ext > Limite) ax_d = AncoraMax;
          end else begin
            if ({1'b0, ay_q} + Ext > Limite) ay_d = AncoraMax;
          end
        end else if (b_cima) begin
          if (fim_y < Limite) ay_d = ay_q + 4'd1;
        end else if (b_baixo) begin
          if (ay_q > CodMin) ay_d = ay_q - 4'd1;
        end else if (b_esquerda) begin
          if (ax_q > CodMin) ax_d = ax_q - 4'd1;
        end else if (b_direita) begin
          if (fim_x < Limite) ax_d = ax_q + 4'd1;
        end
      end
      StVerificando: begin
        if (ocupacao[endereco_celula(cel_x, cel_y)]) begin
          rej_d    = 1'b1;
          estado_d = StPosicionando;
        end else if (idx_q == IdxUltimo) begin
          estado_d = StFixado;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StFixado: begin
        estado_d = StFixado;
      end
      default: estado_d = StOcioso;
    endcase
  end

  // Packed vector from current state; cells past the ship repeat its last cell.
  always_comb begin
    logic [3:0] desloc;
    desloc = 4'd0;
    pos_d  = '0;
    pos_d[BitVisivel]    = (estado_q != StOcioso);
    pos_d[BitOrientacao] = orient_q;
    pos_d[BitFixado]     = (estado_q == StFixado);
    for (int k = 0; k < NumCelulas; k++) begin
      desloc = (k < int'(TAMANHO)) ? 4'(k) : 4'(TAMANHO - 1);
      pos_d[CellStride*k + CellXOffset -: 4] = ax_q + (vertical ? 4'd0 : desloc);
      pos_d[CellStride*k + CellYOffset -: 4] = ay_q + (vertical ? desloc : 4'd0);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= StOcioso;
      ax_q     <= 4'(X_INICIAL);
      ay_q     <= 4'(Y_INICIAL);
      orient_q <= OrientHorizontal;
      idx_q    <= 3'd0;
      rej_q    <= 1'b0;
      pos_q    <= '0;
    end else begin
      estado_q <= estado_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      orient_q <= orient_d;
      idx_q    <= idx_d;
      rej_q    <= rej_d;
      pos_q    <= pos_d;
    end
  end

  assign posicoesEmbarcacao = pos_q;
  assign pronto             = (estado_q == StFixado);
  assign rejeitado          = rej_q;

endmodule

// File: tb/tb_posicionador_embarcacao.sv
// Directed bench for posicionador_embarcacao (TAMANHO=4, anchor starts at (1,1)).
module tb_posicionador_embarcacao;

  localparam int BDir = 0, BEsq = 1, BBaixo = 2, BCima = 3, BGirar = 4, BConf = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        habilita;
  logic [5:0]  btn;
  logic [63:0] ocupacao;
  logic [63:0] pos;
  logic        pronto, rejeitado;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  posicionador_embarcacao #(
    .TAMANHO(4), .X_INICIAL(1), .Y_INICIAL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .habilita(habilita),
    .cima(btn[BCima]),
    .baixo(btn[BBaixo]),
    .esquerda(btn[BEsq]),
    .direita(btn[BDir]),
    .girar(btn[BGirar]),
    .confirmar(btn[BConf]),
    .ocupacao(ocupacao),
    .posicoesEmbarcacao(pos),
    .pronto(pronto),
    .rejeitado(rejeitado)
  );

  // Expected vector for a 4-cell ship at anchor (ax,ay), orientation v, flags fl.
  function automatic logic [63:0] vetor(input int ax, input int ay, input int v,
                                        input logic [2:0] fl);
    logic [63:0] r;
    int o, x, y;
    r = '0;
    r[2:0] = fl;
    for (int k = 0; k < 7; k++) begin
      o = (k < 4) ? k : 3;
      x = (v != 0) ? ax : ax + o;
      y = (v != 0) ? ay + o : ay;
      r[8*k+3 +: 4] = x[3:0];
      r[8*k+7 +: 4] = y[3:0];
    end
    return r;
  endfunction

  // One press: high for a cycle, low for a cycle; vector reflects it on return.
  task automatic press(input int b);
    btn[b] = 1'b1;
    @(negedge clk);
    btn[b] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; habilita = 1'b0; btn = '0; ocupacao = '0;
    repeat (2) @(negedge clk);
    total++; if (pos !== 64'd0) begin bad++; $display("FAIL reset_pos got=%h want=0", pos); end
    total++; if (pronto !== 1'b0) begin bad++; $display("FAIL reset_pronto got=%b want=0", pronto); end
    total++; if (rejeitado !== 1'b0) begin bad++; $display("FAIL reset_rej got=%b want=0", rejeitado); end
    rst = 1'b0; habilita = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (pos !== vetor(1, 1, 0, 3'b001)) begin
      bad++; $display("FAIL start_vec got=%h want=%h", pos, vetor(1, 1, 0, 3'b001));
    end
    total++; if (pos[63:59] !== 5'd0) begin bad++; $display("FAIL top_bits got=%b want=0", pos[63:59]); end
    total++; if (pos[30:27] !== 4'd4) begin bad++; $display("FAIL cell3_x got=%0d want=4", pos[30:27]); end
    total++; if (pos[54:51] !== 4'd4) begin bad++; $display("FAIL cell6_x got=%0d want=4", pos[54:51]); end
    total++; if (pos[2:0] !== 3'b001) begin bad++; $display("FAIL start_flags got=%b want=001", pos[2:0]); end
  endtask

  task automatic test_direita();
    int exp_x [5] = '{2, 3, 4, 5, 5};
    for (int i = 0; i < 5; i++) begin
      press(BDir);
      total++; if (pos[6:3] !== 4'(exp_x[i])) begin
        bad++; $display("FAIL dir_anchor%0d got=%0d want=%0d", i, pos[6:3], exp_x[i]);
      end
      total++; if (pos[30:27] !== 4'(exp_x[i] + 3)) begin
        bad++; $display("FAIL dir_cell3_%0d got=%0d want=%0d", i, pos[30:27], exp_x[i] + 3);
      end
    end
    repeat (3) press(BEsq);
    total++; if (pos !== vetor(2, 1, 0, 3'b001)) begin
      bad++; $display("FAIL esq_vec got=%h want=%h", pos, vetor(2, 1, 0, 3'b001));
    end
    btn[BDir] = 1'b1;
    repeat (10) @(negedge clk);
    btn[BDir] = 1'b0;
    @(negedge clk);
    total++; if (pos !== vetor(3, 1, 0, 3'b001)) begin
      bad++; $display("FAIL hold_once got=%h want=%h", pos, vetor(3, 1, 0, 3'b001));
    end
  endtask

  task automatic test_girar();
    repeat (2) press(BDir);
    repeat (6) press(BCima);
    total++; if (pos !== vetor(5, 7, 0, 3'b001)) begin
      bad++; $display("FAIL pre_rot got=%h want=%h", pos, vetor(5, 7, 0, 3'b001));
    end
    press(BGirar);
    total++; if (pos !== vetor(5, 5, 1, 3'b011)) begin
      bad++; $display("FAIL rot_clamp_y got=%h want=%h", pos, vetor(5, 5, 1, 3'b011));
    end
    press(BCima);
    total++; if (pos !== vetor(5, 5, 1, 3'b011)) begin
      bad++; $display("FAIL cima_noop got=%h want=%h", pos, vetor(5, 5, 1, 3'b011));
    end
    repeat (4) press(BDir);
    total++; if (pos !== vetor(8, 5, 1, 3'b011)) begin
      bad++; $display("FAIL vert_dir got=%h want=%h", pos, vetor(8, 5, 1, 3'b011));
    end
    press(BGirar);
    total++; if (pos !== vetor(5, 5, 0, 3'b001)) begin
      bad++; $display("FAIL rot_clamp_x got=%h want=%h", pos, vetor(5, 5, 0, 3'b001));
    end
  endtask

  task automatic test_simultaneo();
    btn[BDir] = 1'b1; btn[BEsq] = 1'b1; btn[BGirar] = 1'b1;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
    total++; if (pos !== vetor(5, 5, 1, 3'b011)) begin
      bad++; $display("FAIL simult got=%h want=%h", pos, vetor(5, 5, 1, 3'b011));
    end
    press(BGirar);
    repeat (4) press(BBaixo);
    repeat (4) press(BEsq);
    total++; if (pos !== vetor(1, 1, 0, 3'b001)) begin
      bad++; $display("FAIL home got=%h want=%h", pos, vetor(1, 1, 0, 3'b001));
    end
  endtask

  task automatic test_confirmar();
    logic [5:0] rej_seen, pr_seen;
    ocupacao = 64'd0;
    ocupacao[2] = 1'b1;
    btn[BConf] = 1'b1;
    rej_seen = '0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      btn[BConf] = 1'b0;
      rej_seen[i-1] = rejeitado;
    end
    total++; if (rej_seen !== 6'b001000) begin
      bad++; $display("FAIL rej_pulse got=%b want=001000", rej_seen);
    end
    total++; if (pronto !== 1'b0) begin bad++; $display("FAIL rej_pronto got=%b want=0", pronto); end
    total++; if (pos !== vetor(1, 1, 0, 3'b001)) begin
      bad++; $display("FAIL rej_vec got=%h want=%h", pos, vetor(1, 1, 0, 3'b001));
    end
    press(BDir);
    total++; if (pos[6:3] !== 4'd2) begin bad++; $display("FAIL rej_moves got=%0d want=2", pos[6:3]); end
    press(BEsq);
    ocupacao = 64'd0;
    btn[BConf] = 1'b1;
    pr_seen = '0; rej_seen = '0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      btn[BConf] = 1'b0;
      pr_seen[i-1]  = pronto;
      rej_seen[i-1] = rejeitado;
    end
    total++; if (pr_seen !== 6'b110000) begin
      bad++; $display("FAIL pronto_timing got=%b want=110000", pr_seen);
    end
    total++; if (rej_seen !== 6'b000000) begin
      bad++; $display("FAIL clean_rej got=%b want=000000", rej_seen);
    end
    total++; if (pos !== vetor(1, 1, 0, 3'b101)) begin
      bad++; $display("FAIL locked_vec got=%h want=%h", pos, vetor(1, 1, 0, 3'b101));
    end
    press(BDir);
    press(BGirar);
    habilita = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (pos !== vetor(1, 1, 0, 3'b101)) begin
      bad++; $display("FAIL locked_hold got=%h want=%h", pos, vetor(1, 1, 0, 3'b101));
    end
    total++; if (pronto !== 1'b1) begin bad++; $display("FAIL locked_pronto got=%b want=1", pronto); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; habilita = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (pronto !== 1'b0) begin bad++; $display("FAIL rst_unlock got=%b want=0", pronto); end
    press(BDir);
    total++; if (pos !== vetor(2, 1, 0, 3'b001)) begin
      bad++; $display("FAIL pre_mid got=%h want=%h", pos, vetor(2, 1, 0, 3'b001));
    end
    btn[BConf] = 1'b1;
    @(negedge clk);
    btn[BConf] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (pos !== 64'd0) begin bad++; $display("FAIL mid_pos got=%h want=0", pos); end
    total++; if (pronto !== 1'b0) begin bad++; $display("FAIL mid_pronto got=%b want=0", pronto); end
    total++; if (rejeitado !== 1'b0) begin bad++; $display("FAIL mid_rej got=%b want=0", rejeitado); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (pos !== vetor(1, 1, 0, 3'b001)) begin
      bad++; $display("FAIL restart got=%h want=%h", pos, vetor(1, 1, 0, 3'b001));
    end
  endtask

  initial begin
    btn = '0; rst = 1'b1; habilita = 1'b0; ocupacao = '0;
    @(negedge clk);
    test_reset();
    test_direita();
    test_girar();
    test_simultaneo();
    test_confirmar();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
